// File: rtl/display_pkg.sv
// Shared constants, engine state type and BCD correction helper for the BCD display scanner.
`timescale 1ns/1ps
package display_pkg;
    localparam int DIGITS      = 4;
    localparam int BIN_W       = 14;
    localparam int BCD_W       = 16;
    localparam int CONV_CYCLES = 14;
    localparam logic [BIN_W-1:0] MAX_VALUE = 14'd9999;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } eng_state_t;

    // Shift-add-3 correction applied to one BCD nibble before each shift
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: clamps the input to 9999 and produces four
// BCD digits after a fixed 14-cycle conversion; bcd holds the last completed result.
`timescale 1ns/1ps
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_value,
    output logic             ready,
    output logic             ovf,
    output logic [BCD_W-1:0] bcd
);
    eng_state_t             r_state;
    logic [3:0]             r_cnt;
    logic [BIN_W-1:0]       r_bin;
    logic [BCD_W-1:0]       r_acc;
    logic [BCD_W-1:0]       r_bcd;
    logic                   r_ovf;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+BIN_W-1:0] w_shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_adj[4*gi +: 4] = dabble_adj(r_acc[4*gi +: 4]);
        end
    endgenerate

    assign w_shifted = {w_adj, r_bin} << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_acc   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (load) begin
                r_bin   <= (bin_value > MAX_VALUE) ? MAX_VALUE : bin_value;
                r_acc   <= '0;
                r_ovf   <= (bin_value > MAX_VALUE);
                r_cnt   <= '0;
                r_state <= CONV;
            end
        end else begin
            {r_acc, r_bin} <= w_shifted;
            r_cnt          <= r_cnt + 4'd1;
            // Digits only change once the final shift is done
            if (r_cnt == 4'(CONV_CYCLES - 1)) begin
                r_bcd   <= w_shifted[BIN_W +: BCD_W];
                r_state <= IDLE;
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign ovf   = r_ovf;
    assign bcd   = r_bcd;
endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD conversion plus four-digit common-anode scan multiplexer.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BIN_W-1:0]  bin_value,
    output logic              ready,
    output logic              ovf,
    output logic [3:0]        digit_num,
    output logic [DIGITS-1:0] anode
);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;
    logic [BCD_W-1:0] w_bcd;
    logic [3:0]       w_digits [DIGITS];
    logic             w_blank_sel;

    bin2bcd_seq u_engine (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bin_value (bin_value),
        .ready     (ready),
        .ovf       (ovf),
        .bcd       (w_bcd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign w_digits[gi] = w_bcd[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A position is dark when it and every higher digit are zero; position 0 always lit
    logic [DIGITS-1:0] w_blank;
    assign w_blank[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            if (gi == DIGITS - 1) begin : g_top
                assign w_blank[gi] = (w_digits[gi] == 4'd0);
            end else begin : g_mid
                assign w_blank[gi] = (w_digits[gi] == 4'd0) && w_blank[gi+1];
            end
        end
    endgenerate
    assign w_blank_sel = w_blank[r_idx];
`else
    assign w_blank_sel = 1'b0;
`endif

    assign digit_num = w_digits[r_idx];
    assign anode     = ~(4'b0001 << r_idx) | ({3'b000, w_blank_sel} << r_idx);
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench: vector table, randomized loads and reset/ignored-load corners,
// compared against an arithmetic model of the displayed value and scan position.
`timescale 1ns/1ps
module tb_bcd_display_scanner;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [13:0] bin_value;
    logic        ready;
    logic        ovf;
    logic [3:0]  digit_num;
    logic [3:0]  anode;

    int checks = 0;
    int errors = 0;
    int cyc;
    int shown = 0;
    int p10 [4] = '{1, 10, 100, 1000};

    typedef struct {
        int bin;
        int exp_val;
        bit exp_ovf;
    } vec_t;
    vec_t vecs [9];

    bcd_display_scanner #(.SCAN_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bin_value (bin_value),
        .ready     (ready),
        .ovf       (ovf),
        .digit_num (digit_num),
        .anode     (anode)
    );

    always #5 clk = ~clk;

    // Edges since reset release: scan position is simply (cyc / SD) mod 4
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_anode(input int idx, input int val);
        int a;
        a = 15 & ~(1 << idx);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx >= 1 && val < p10[idx]) a = 15;
`endif
        return a;
    endfunction

    task automatic chk_scan(input string tag, input int val);
        int idx;
        idx = (cyc / SD) % 4;
        chk({tag, "_digit"}, int'(digit_num), (val / p10[idx]) % 10);
        chk({tag, "_anode"}, int'(anode), exp_anode(idx, val));
    endtask

    task automatic check_disp(input int val);
        for (int c = 0; c < 4 * SD; c++) begin
            chk_scan("scan", val);
            tick();
        end
    endtask

    task automatic do_load(input int v, input int pulse_at, input int exp_val, input bit exp_ovf);
        int w;
        int lat;
        w = 0;
        while (!ready && w < 40) begin
            tick();
            w++;
        end
        chk("ready_before_load", int'(ready), 1);
        load = 1'b1;
        bin_value = 14'(v);
        tick();
        load = 1'b0;
        chk("ready_fall", int'(ready), 0);
        chk("ovf_accept", int'(ovf), int'(exp_ovf));
        lat = -1;
        for (int t = 1; t <= 30; t++) begin
            if (t == pulse_at) begin
                load = 1'b1;
                bin_value = 14'd1111;
            end
            tick();
            load = 1'b0;
            if (ready) begin
                lat = t;
                break;
            end
            chk_scan("hold", shown);
        end
        chk("latency", lat, 14);
        shown = exp_val;
        $display("load %0d -> latency %0d, expect display %0d ovf %0d", v, lat, exp_val, exp_ovf);
        check_disp(exp_val);
        chk("ovf_hold", int'(ovf), int'(exp_ovf));
    endtask

    initial begin
        vecs[0] = '{1234, 1234, 1'b0};
        vecs[1] = '{10000, 9999, 1'b1};
        vecs[2] = '{42, 42, 1'b0};
        vecs[3] = '{0, 0, 1'b0};
        vecs[4] = '{9999, 9999, 1'b0};
        vecs[5] = '{16383, 9999, 1'b1};
        vecs[6] = '{7, 7, 1'b0};
        vecs[7] = '{1005, 1005, 1'b0};
        vecs[8] = '{10, 10, 1'b0};

        rst = 1'b1;
        load = 1'b0;
        bin_value = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_digit", int'(digit_num), 0);
        chk("rst_anode", int'(anode), 4'b1110);
        rst = 1'b0;
        check_disp(0);

        for (int i = 0; i < 9; i++)
            do_load(vecs[i].bin, 0, vecs[i].exp_val, vecs[i].exp_ovf);

        // A load arriving mid-conversion must be dropped
        do_load(5678, 5, 5678, 1'b0);
        chk("ignored_load_ready", int'(ready), 1);

        for (int i = 0; i < 10; i++) begin
            int v;
            v = int'($urandom_range(16383, 0));
            do_load(v, 0, (v > 9999) ? 9999 : v, v > 9999);
        end

        // Reset during conversion cycle 7 of an overflowing load
        load = 1'b1;
        bin_value = 14'd12000;
        tick();
        load = 1'b0;
        chk("abort_ovf_set", int'(ovf), 1);
        repeat (7) tick();
        chk("abort_busy", int'(ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_ready", int'(ready), 1);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_digit", int'(digit_num), 0);
        chk("abort_anode", int'(anode), 4'b1110);
        rst = 1'b0;
        shown = 0;
        $display("reset mid-conversion, expect display 0");
        check_disp(0);
        check_disp(0);
        chk("abort_idle", int'(ready), 1);

        do_load(3, 0, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
